// File: rtl/btn_counter_pkg.sv
// Shared constants and types for the debounced push-button step counter.
package btn_counter_pkg;

    localparam int unsigned SYNC_STAGES      = 2;
    localparam int unsigned DEBOUNCE_DEFAULT = 1_250_000;

    typedef logic [3:0] count_t;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchronizer, stability-counter debouncer and a
// rising-edge detector that emits a single-cycle press.
module btn_debounce
    import btn_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic                   level_prev_q;
    logic [CW-1:0]          stable_cnt_q, stable_cnt_d;
    logic                   btn_sync;

    assign btn_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], btn_raw};
        level_d      = level_q;
        stable_cnt_d = '0;
        if (btn_sync != level_q) begin
            // Flip on the DEBOUNCE_CYCLES-th consecutive differing sample.
            if (stable_cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = btn_sync;
            end else begin
                stable_cnt_d = stable_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            stable_cnt_q <= '0;
        end else begin
            sync_q       <= sync_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            stable_cnt_q <= stable_cnt_d;
        end
    end

    assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/btn_step_counter.sv
// Debounced up/down/clear step counter whose binary count feeds the Gray
// converter; step_pulse and wrap are registered alongside the count.
module btn_step_counter
    import btn_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned WIDTH           = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             step_pulse,
    output logic             wrap
);

    logic             up_press, down_press, clr_press;
    logic [WIDTH-1:0] count_q, count_d;
    logic             step_pulse_q, step_pulse_d;
    logic             wrap_q, wrap_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_up),
        .press   (up_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_down),
        .press   (down_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_clr),
        .press   (clr_press)
    );

    always_comb begin
        count_d      = count_q;
        step_pulse_d = 1'b0;
        wrap_d       = 1'b0;
        if (en) begin
            if (clr_press) begin
                count_d = '0;
            end else if (up_press && !down_press) begin
                count_d = count_q + 1'b1;
                wrap_d  = (count_q == '1);
            end else if (down_press && !up_press) begin
                count_d = count_q - 1'b1;
                wrap_d  = (count_q == '0);
            end
            // A clear at zero is not a step.
            step_pulse_d = (count_d != count_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            step_pulse_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            count_q      <= count_d;
            step_pulse_q <= step_pulse_d;
            wrap_q       <= wrap_d;
        end
    end

    assign count      = count_q;
    assign step_pulse = step_pulse_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_btn_step_counter.sv
// Directed bench for btn_step_counter with DEBOUNCE_CYCLES=4.
module tb_btn_step_counter;

    localparam int unsigned DC = 4;
    localparam int unsigned W  = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   btns = '0;   // {clr, down, up}
    logic         en = 1'b1;
    logic [W-1:0] count;
    logic         step_pulse;
    logic         wrap;

    int errors = 0;
    int checks = 0;
    int n_step = 0;
    int n_wrap = 0;
    int s0, w0;

    btn_step_counter #(.DEBOUNCE_CYCLES(DC), .WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up     (btns[0]),
        .btn_down   (btns[1]),
        .btn_clr    (btns[2]),
        .en         (en),
        .count      (count),
        .step_pulse (step_pulse),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    // Pulse tally, sampled mid-cycle
    always @(negedge clk) begin
        if (step_pulse) n_step <= n_step + 1;
        if (wrap)       n_wrap <= n_wrap + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 2 time units past the last edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btns  = '0;
        en    = 1'b1;
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
    endtask

    task automatic press_btn(input logic [2:0] mask);
        btns = mask;
        cycles(10);
        btns = '0;
        cycles(10);
    endtask

    initial begin
        // Reset state
        cycles(2);
        check("rst_count", 32'(count), 0);
        check("rst_step", 32'(step_pulse), 0);
        check("rst_wrap", 32'(wrap), 0);
        rst_n = 1'b1;
        cycles(2);

        // Single press latency: increments at edge k+6
        s0 = n_step;
        btns = 3'b001;
        cycles(6);
        check("lat_count_k5", 32'(count), 0);
        check("lat_step_k5", 32'(step_pulse), 0);
        cycles(1);
        check("lat_count_k6", 32'(count), 1);
        check("lat_step_k6", 32'(step_pulse), 1);
        check("lat_wrap_k6", 32'(wrap), 0);
        cycles(1);
        check("lat_step_k7", 32'(step_pulse), 0);
        cycles(12);
        btns = '0;
        cycles(10);
        check("lat_count_end", 32'(count), 1);
        check("lat_nstep", 32'(n_step - s0), 1);

        // Glitches of 3 cycles never debounce
        do_reset();
        s0 = n_step;
        for (int i = 0; i < 10; i++) begin
            btns = 3'b001;
            cycles(3);
            btns = '0;
            cycles(3);
        end
        cycles(10);
        check("glitch_count", 32'(count), 0);
        check("glitch_nstep", 32'(n_step - s0), 0);

        // 16 up presses wrap 15->0, then down wraps 0->15
        do_reset();
        w0 = n_wrap;
        for (int i = 1; i <= 16; i++) begin
            press_btn(3'b001);
            if (i == 15) begin
                check("up15_count", 32'(count), 15);
                check("up15_nwrap", 32'(n_wrap - w0), 0);
            end
        end
        check("up16_count", 32'(count), 0);
        check("up16_nwrap", 32'(n_wrap - w0), 1);
        press_btn(3'b010);
        check("down_count", 32'(count), 15);
        check("down_nwrap", 32'(n_wrap - w0), 2);
        press_btn(3'b010);
        check("down2_count", 32'(count), 14);
        check("down2_nwrap", 32'(n_wrap - w0), 2);

        // Up+down cancel, then clr beats up
        do_reset();
        for (int i = 0; i < 5; i++) press_btn(3'b001);
        check("pre5_count", 32'(count), 5);
        s0 = n_step;
        w0 = n_wrap;
        press_btn(3'b011);
        check("updn_count", 32'(count), 5);
        check("updn_nstep", 32'(n_step - s0), 0);
        press_btn(3'b101);
        check("clrup_count", 32'(count), 0);
        check("clrup_nstep", 32'(n_step - s0), 1);
        check("clrup_nwrap", 32'(n_wrap - w0), 0);
        press_btn(3'b100);
        check("clr0_nstep", 32'(n_step - s0), 1);

        // Press during en=0 is lost, not deferred
        s0 = n_step;
        en = 1'b0;
        btns = 3'b001;
        cycles(10);
        en = 1'b1;
        cycles(10);
        btns = '0;
        cycles(10);
        check("en_count", 32'(count), 0);
        check("en_nstep", 32'(n_step - s0), 0);

        // Async reset mid-debounce with button held through release
        press_btn(3'b001);
        check("pre_rst_count", 32'(count), 1);
        btns = 3'b001;
        cycles(4);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 0);
        check("async_rst_step", 32'(step_pulse), 0);
        cycles(2);
        rst_n = 1'b1;
        s0 = n_step;
        cycles(6);
        check("rel_count_k5", 32'(count), 0);
        cycles(1);
        check("rel_count_k6", 32'(count), 1);
        check("rel_step_k6", 32'(step_pulse), 1);
        cycles(12);
        btns = '0;
        cycles(10);
        check("rel_count_end", 32'(count), 1);
        check("rel_nstep", 32'(n_step - s0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
